instr_sequencer: RTL

- Multi-cycle control FSM that sequences the 16-bit register-file/ALU datapath.
- Per instruction: fetch from instruction memory over a req/valid handshake, latch it into an instruction register, drive register-file read addresses, compute the ALU result, issue a single-cycle write-back, advance the PC.
- Sits between instruction memory and the register file; it is the only agent driving register-file ports.

---
 rtl/instr_sequencer_pkg.sv | 41 ++++
 rtl/instr_sequencer_alu.sv | 35 +++
 rtl/instr_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout,
// opcode values and the control FSM state encoding.
package instr_sequencer_pkg;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 13;
    localparam int DST_MSB  = 12;
    localparam int DST_LSB  = 10;
    localparam int SRC1_MSB = 9;
    localparam int SRC1_LSB = 7;
    localparam int SRC2_MSB = 6;
    localparam int SRC2_LSB = 4;
    localparam int IMM_MSB  = 6;
    localparam int IMM_LSB  = 0;

    localparam int OPC_W     = OPC_MSB - OPC_LSB + 1;
    localparam int RADDR_W   = DST_MSB - DST_LSB + 1;
    localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;
    localparam int RETIRED_W = 16;

    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_ADDI = 3'b001;
    localparam logic [OPC_W-1:0] OP_SUBI = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Only the four arithmetic opcodes produce a register-file write.
    function automatic logic op_writes(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/instr_sequencer_alu.sv
// Combinational ALU for the sequencer: register/register and register/immediate
// add and subtract, wrapping modulo 2^DATA_WIDTH, plus write/halt decode.
module seq_alu
    import instr_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [OPC_W-1:0]      op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [IMM_W-1:0]      imm_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  wr_en_o,
    output logic                  halt_o
);

    logic [DATA_WIDTH-1:0] imm_ext;

    assign imm_ext = {{(DATA_WIDTH - IMM_W){imm_i[IMM_W-1]}}, imm_i};

    always_comb begin
        result_o = '0;
        unique case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_ADDI: result_o = a_i + imm_ext;
            OP_SUBI: result_o = a_i - imm_ext;
            OP_SUB:  result_o = a_i - b_i;
            default: result_o = '0;
        endcase
    end

    assign wr_en_o = op_writes(op_i);
    assign halt_o  = (op_i == OP_HALT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch over a req/valid handshake, decode, execute,
// write back, advance the PC. Sole driver of the register-file ports.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_valid,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [RADDR_W-1:0]    rf_raddr1,
    output logic [RADDR_W-1:0]    rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic [RADDR_W-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_we,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  busy,
    output logic                  halted,
    output logic [RETIRED_W-1:0]  retired
);

    state_e                state_q,   state_d;
    logic [PC_WIDTH-1:0]   pc_q,      pc_d;
    logic [DATA_WIDTH-1:0] ir_q,      ir_d;
    logic [DATA_WIDTH-1:0] result_q,  result_d;
    logic [RETIRED_W-1:0]  retired_q, retired_d;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_wr_en;
    logic                  alu_halt;

    seq_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .op_i    (ir_q[OPC_MSB:OPC_LSB]),
        .a_i     (rf_rdata1),
        .b_i     (rf_rdata2),
        .imm_i   (ir_q[IMM_MSB:IMM_LSB]),
        .result_o(alu_result),
        .wr_en_o (alu_wr_en),
        .halt_o  (alu_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            result_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        retired_d = retired_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = alu_halt ? ST_HALT : ST_WB;
            end
            ST_WB: begin
                pc_d      = pc_q + PC_WIDTH'(1);
                retired_d = retired_q + RETIRED_W'(1);
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read addresses follow IR, so they stay stable from DECODE through EXEC.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign rf_raddr1 = ir_q[SRC1_MSB:SRC1_LSB];
    assign rf_raddr2 = ir_q[SRC2_MSB:SRC2_LSB];
    assign rf_waddr  = ir_q[DST_MSB:DST_LSB];
    assign rf_wdata  = result_q;
    assign rf_we     = (state_q == ST_WB) && alu_wr_en;
    assign pc        = pc_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted    = (state_q == ST_HALT);
    assign retired   = retired_q;

endmodule
